countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Counts down from a preset M:SS.00 to 0:00.00 in centisecond steps. It is the
//   down-counting counterpart of the stopwatch core and uses the same digit
//   outputs, so it drives the existing hex_to_seven_seg displays directly.
//  Sits between var_clk (CLK, 100 Hz nominal) and the display drivers.
//  Flags expiry and raises an alarm for a fixed number of cycles.
// PARAMETERS
//  MIN_MAX       9    largest legal minute digit; higher presets clamp to it
//  ALARM_CYCLES  200  cycles ALARM stays high after expiry (2 s at 100 Hz); >=1
// PORTS
//  CLK            in   1  counting clock, one edge = 0.01 s
//  RESET_N        in   1  asynchronous, active-low reset
//  LOAD           in   1  synchronous load of preset (level, sampled each edge)
//  ENABLE         in   1  run when 1, pause when 0 (level)
//  PRESET_MIN     in   4  preset minutes digit
//  PRESET_TENSEC  in   4  preset tens-of-seconds digit (0-5)
//  PRESET_SEC     in   4  preset seconds digit (0-9)
//  MIN            out  4  BCD minutes
//  TENSEC         out  4  BCD tens of seconds, 0-5
//  SEC            out  4  BCD seconds
//  DECISEC        out  4  BCD tenths
//  CENTISEC       out  4  BCD hundredths
//  RUNNING        out  1  1 while in RUN
//  DONE           out  1  level, 1 in EXPIRED
//  ALARM          out  1  1 for exactly ALARM_CYCLES cycles starting at expiry
// BEHAVIOUR
//  Reset (async, RESET_N=0): all digits 0, state IDLE, RUNNING/DONE/ALARM 0,
//   alarm counter 0. Reset mid-run aborts immediately; no resume on release.
//  All outputs are registered; every change appears on the CLK edge that
//   samples the cause (1-cycle latency from inputs).
//  States: IDLE (count zero, unarmed), ARMED (nonzero, paused), RUN, EXPIRED.
//  LOAD has priority over ENABLE in every state. On LOAD:
//   - MIN<=min(PRESET_MIN,MIN_MAX); TENSEC<=min(PRESET_TENSEC,5);
//     SEC<=min(PRESET_SEC,9); DECISEC=CENTISEC<=0.
//   - State ARMED if the clamped preset is nonzero, else IDLE.
//   - DONE<=0, ALARM<=0, alarm counter cleared.
//  ARMED & ENABLE -> RUN; the first decrement happens on that same edge.
//  RUN & !ENABLE -> ARMED with the count held (pause).
//  RUN & ENABLE: decrement by one centisecond using a borrow chain.
//   - CENTISEC, DECISEC and SEC wrap 0->9; TENSEC wraps 0->5; MIN wraps 0->9.
//   - Borrow ripples within the cycle.
//  RUN, count==0:00.01 & ENABLE: count->0:00.00, ->EXPIRED, DONE=1,
//   ALARM=1, alarm counter loaded with ALARM_CYCLES-1.
//  EXPIRED: count held at zero (never underflows); ENABLE ignored.
//   ALARM drops after ALARM_CYCLES total cycles high.
//   Only LOAD or reset leaves EXPIRED.
//  IDLE: ENABLE ignored; count stays zero.
//  LOAD & ENABLE on the same edge: load only; counting starts next edge.
// STRUCTURE
//  Shared package/include: state encodings (IDLE/ARMED/RUN/EXPIRED) and the
//   digit limits (DIGIT9=9, DIGIT5=5), shared with the stopwatch core.
//  One sub-module, bcd_down_digit:
//   - inputs: value[3:0], limit[3:0], borrow_in; outputs: next[3:0], borrow_out.
//   - combinational.
//   - instantiated five times, chained CENTISEC->MIN.
//  Top: state register, digit registers, load/clamp mux, alarm counter.
// TESTING
//  1. Reset, LOAD preset 0:10, ENABLE=1 for 1000 cycles -> 0:09.99 after
//     1 cycle, 0:00.00 at cycle 1000, DONE=1, ALARM high 200 cycles.
//  2. Preset 1:00, run 1 cycle -> 0:59.99; check TENSEC wraps to 5, not 9.
//  3. Preset 0:05, run 100 cycles, ENABLE=0 for 50 cycles -> holds 0:04.00,
//     RUNNING=0; re-enable resumes at 0:03.99.
//  4. Presets TENSEC=7, SEC=12, MIN=15 -> loads 9:59.00; preset 0:00 -> IDLE,
//     ENABLE ignored, DONE=0.
//  5. RESET_N low between edges mid-run -> digits 0 immediately (async);
//     LOAD during ALARM clears DONE and ALARM on the next edge.
//  6. LOAD and ENABLE high together with preset 0:01 -> 0:01.00 held for that
//     edge, 0:00.99 on the next.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer and stopwatch cores: FSM states, BCD digit
// limits and a clamp helper for preset digits.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StRun,
    StExpired
  } state_e;

  localparam logic [3:0] Digit9 = 4'd9;
  localparam logic [3:0] Digit5 = 4'd5;

  function automatic logic [3:0] clamp_digit(input logic [3:0] value, input logic [3:0] lim);
    return (value > lim) ? lim : value;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control, preset and display-digit bundle between the timer core and its user.
interface countdown_timer_if;
  logic       load;
  logic       enable;
  logic [3:0] preset_min;
  logic [3:0] preset_tensec;
  logic [3:0] preset_sec;
  logic [3:0] min;
  logic [3:0] tensec;
  logic [3:0] sec;
  logic [3:0] decisec;
  logic [3:0] centisec;
  logic       running;
  logic       done;
  logic       alarm;

  modport master (
    output load, enable, preset_min, preset_tensec, preset_sec,
    input  min, tensec, sec, decisec, centisec, running, done, alarm
  );

  modport slave (
    input  load, enable, preset_min, preset_tensec, preset_sec,
    output min, tensec, sec, decisec, centisec, running, done, alarm
  );
endinterface

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD digit of the down-counting borrow chain; wraps 0 -> limit when borrowed from.
module bcd_down_digit (
  input  logic [3:0] value,
  input  logic [3:0] limit,
  input  logic       borrow_in,
  output logic [3:0] next,
  output logic       borrow_out
);

  always_comb begin
    next       = value;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (value == 4'd0) begin
        next       = limit;
        borrow_out = 1'b1;
      end else begin
        next = value - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// M:SS.cc countdown timer: loads a clamped preset, counts down one centisecond per edge,
// flags expiry and holds the alarm for a fixed number of cycles.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned MinMax      = 9,
  parameter int unsigned AlarmCycles = 200
) (
  input logic              clk,
  input logic              rst_n,
  countdown_timer_if.slave bus
);

  localparam int unsigned CntW   = (AlarmCycles > 1) ? $clog2(AlarmCycles) : 1;
  localparam logic [3:0]  MinLim = 4'(MinMax);
  // Index 0 is centiseconds, index 4 is minutes.
  localparam logic [4:0][3:0] Limits = {Digit9, Digit5, Digit9, Digit9, Digit9};

  state_e          state_q;
  logic [4:0][3:0] dig_q;
  logic [4:0][3:0] dig_dec;
  logic [5:0]      borrow;
  logic [CntW-1:0] alarm_cnt_q;
  logic            running_q, done_q, alarm_q;
  logic [4:0][3:0] preset;
  logic            preset_zero;
  logic            reach_zero;

  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < 5; i++) begin : g_digit
    bcd_down_digit u_digit (
      .value     (dig_q[i]),
      .limit     (Limits[i]),
      .borrow_in (borrow[i]),
      .next      (dig_dec[i]),
      .borrow_out(borrow[i+1])
    );
  end

  assign preset = {clamp_digit(bus.preset_min, MinLim),
                   clamp_digit(bus.preset_tensec, Digit5),
                   clamp_digit(bus.preset_sec, Digit9),
                   4'd0, 4'd0};
  assign preset_zero = (preset == '0);
  // Decrement lands on zero without borrowing out of the minutes digit.
  assign reach_zero  = (dig_dec == '0) && !borrow[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dig_q       <= '0;
      alarm_cnt_q <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      alarm_q     <= 1'b0;
    end else if (bus.load) begin
      dig_q       <= preset;
      state_q     <= preset_zero ? StIdle : StArmed;
      alarm_cnt_q <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StArmed, StRun: begin
          if (bus.enable) begin
            dig_q <= dig_dec;
            if (reach_zero) begin
              state_q     <= StExpired;
              running_q   <= 1'b0;
              done_q      <= 1'b1;
              alarm_q     <= 1'b1;
              alarm_cnt_q <= CntW'(AlarmCycles - 1);
            end else begin
              state_q   <= StRun;
              running_q <= 1'b1;
            end
          end else begin
            state_q   <= StArmed;
            running_q <= 1'b0;
          end
        end
        StExpired: begin
          if (alarm_cnt_q != '0) begin
            alarm_cnt_q <= alarm_cnt_q - 1'b1;
          end else begin
            alarm_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.min      = dig_q[4];
  assign bus.tensec   = dig_q[3];
  assign bus.sec      = dig_q[2];
  assign bus.decisec  = dig_q[1];
  assign bus.centisec = dig_q[0];
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.alarm    = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a vector table for load/run/pause/clamp/expiry plus
// hand sequences for the full 10 s run with alarm length and asynchronous reset.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  countdown_timer_if bus ();

  countdown_timer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // {min, tensec, sec, decisec, centisec, running, done, alarm}
  typedef logic [22:0] obs_t;

  typedef struct {
    string      name;
    logic       load;
    logic       enable;
    logic [3:0] pmin;
    logic [3:0] pts;
    logic [3:0] psec;
    int         ncyc;
    obs_t       exp;
  } vec_t;

  function automatic obs_t mk(input logic [3:0] m, ts, s, ds, cs, input logic r, d, a);
    return {m, ts, s, ds, cs, r, d, a};
  endfunction

  function automatic obs_t observe();
    return {bus.min, bus.tensec, bus.sec, bus.decisec, bus.centisec,
            bus.running, bus.done, bus.alarm};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d:%0d%0d.%0d%0d run=%0b done=%0b alarm=%0b, want %0d:%0d%0d.%0d%0d run=%0b done=%0b alarm=%0b",
               name, got[22:19], got[18:15], got[14:11], got[10:7], got[6:3], got[2], got[1],
               got[0], exp[22:19], exp[18:15], exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1],
               exp[0]);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic ld, en, input logic [3:0] m, ts, s);
    bus.load          = ld;
    bus.enable        = en;
    bus.preset_min    = m;
    bus.preset_tensec = ts;
    bus.preset_sec    = s;
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"load_1_00",      1, 0, 1, 0, 0, 1,   mk(1, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"tensec_wrap",    0, 1, 0, 0, 0, 1,   mk(0, 5, 9, 9, 9, 1, 0, 0)});
    vecs.push_back('{"load_0_05",      1, 0, 0, 0, 5, 1,   mk(0, 0, 5, 0, 0, 0, 0, 0)});
    vecs.push_back('{"run_100",        0, 1, 0, 0, 0, 100, mk(0, 0, 4, 0, 0, 1, 0, 0)});
    vecs.push_back('{"pause_50",       0, 0, 0, 0, 0, 50,  mk(0, 0, 4, 0, 0, 0, 0, 0)});
    vecs.push_back('{"resume",         0, 1, 0, 0, 0, 1,   mk(0, 0, 3, 9, 9, 1, 0, 0)});
    vecs.push_back('{"clamp",          1, 0, 15, 7, 12, 1, mk(9, 5, 9, 0, 0, 0, 0, 0)});
    vecs.push_back('{"load_zero",      1, 0, 0, 0, 0, 1,   mk(0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"idle_ignores",   0, 1, 0, 0, 0, 5,   mk(0, 0, 0, 0, 0, 0, 0, 0)});
    vecs.push_back('{"load_and_en",    1, 1, 0, 0, 1, 1,   mk(0, 0, 1, 0, 0, 0, 0, 0)});
    vecs.push_back('{"first_dec",      0, 1, 0, 0, 0, 1,   mk(0, 0, 0, 9, 9, 1, 0, 0)});
    vecs.push_back('{"near_zero",      0, 1, 0, 0, 0, 98,  mk(0, 0, 0, 0, 1, 1, 0, 0)});
    vecs.push_back('{"expire",         0, 1, 0, 0, 0, 1,   mk(0, 0, 0, 0, 0, 0, 1, 1)});
    vecs.push_back('{"hold_zero",      0, 1, 0, 0, 0, 10,  mk(0, 0, 0, 0, 0, 0, 1, 1)});
    vecs.push_back('{"load_in_alarm",  1, 0, 0, 0, 2, 1,   mk(0, 0, 2, 0, 0, 0, 0, 0)});
  end

  initial begin
    int n;
    drive(0, 0, 0, 0, 0);
    step(2);
    check("reset_state", observe(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step(1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].load, vecs[i].enable, vecs[i].pmin, vecs[i].pts, vecs[i].psec);
      step(vecs[i].ncyc);
      check(vecs[i].name, observe(), vecs[i].exp);
    end

    // Full 0:10 run and alarm duration.
    drive(1, 0, 0, 1, 0);
    step(1);
    drive(0, 1, 0, 0, 0);
    step(1);
    check("run10_first", observe(), mk(0, 0, 9, 9, 9, 1, 0, 0));
    step(998);
    check("run10_999", observe(), mk(0, 0, 0, 0, 1, 1, 0, 0));
    step(1);
    check("run10_expire", observe(), mk(0, 0, 0, 0, 0, 0, 1, 1));
    n = 1;
    while (bus.alarm === 1'b1 && n < 300) begin
      step(1);
      if (bus.alarm === 1'b1) n++;
    end
    checks++;
    if (n != 200) begin
      errors++;
      $display("FAIL alarm_len: got %0d cycles high, want 200", n);
    end
    check("after_alarm", observe(), mk(0, 0, 0, 0, 0, 0, 1, 0));

    // Asynchronous reset mid-run, no resume afterwards.
    drive(1, 0, 0, 3, 0);
    step(1);
    drive(0, 1, 0, 0, 0);
    step(10);
    check("pre_reset", observe(), mk(0, 2, 9, 9, 0, 1, 0, 0));
    #2 rst_n = 1'b0;
    #1 check("async_reset", observe(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check("no_resume", observe(), mk(0, 0, 0, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
